// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS sequencer: fetch/decode/exec/mem/wb with shared memory handshake
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_op,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic [1:0] ext_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_src,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_AND, K_OR, K_SLT, K_JR,
    K_ADDIU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL,
    K_ILL
  } kind_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_UP16 = 2'd2;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_REG  = 2'd3;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    kind_t k;
    k = K_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   k = K_ADDU;
          6'h23:   k = K_SUBU;
          6'h24:   k = K_AND;
          6'h25:   k = K_OR;
          6'h2a:   k = K_SLT;
          6'h08:   k = K_JR;
          default: k = K_ILL;
        endcase
      end
      6'h09:   k = K_ADDIU;
      6'h0d:   k = K_ORI;
      6'h0f:   k = K_LUI;
      6'h23:   k = K_LW;
      6'h2b:   k = K_SW;
      6'h04:   k = K_BEQ;
      6'h02:   k = K_J;
      6'h03:   k = K_JAL;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  kind_t      kind_in, kind_q;

  // DECODE judges legality from the live IR; every later state uses the latched copy
  assign kind_in = classify(opcode, funct);
  assign kind_q  = classify(op_q, fn_q);
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      fn_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_op     = PC_INC;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    ext_op    = EXT_ZERO;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    reg_src   = 2'd0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_op    = PC_INC;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: state_d = (kind_in == K_ILL) ? S_TRAP : S_EXEC;

      S_EXEC: begin
        ext_op = EXT_SIGN;
        case (kind_q)
          K_ADDU:  state_d = S_WB;
          K_SUBU:  begin alu_op = ALU_SUB; state_d = S_WB; end
          K_AND:   begin alu_op = ALU_AND; state_d = S_WB; end
          K_OR:    begin alu_op = ALU_OR;  state_d = S_WB; end
          K_SLT:   begin alu_op = ALU_SLT; state_d = S_WB; end
          K_ADDIU: begin alu_src = 1'b1; state_d = S_WB; end
          K_ORI:   begin alu_op = ALU_OR;  alu_src = 1'b1; ext_op = EXT_ZERO; state_d = S_WB; end
          K_LUI:   begin alu_op = ALU_LUI; alu_src = 1'b1; ext_op = EXT_UP16; state_d = S_WB; end
          K_LW, K_SW: begin alu_src = 1'b1; state_d = S_MEM; end
          K_BEQ: begin
            alu_op   = ALU_SUB;
            pc_write = zero;
            pc_op    = PC_BR;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          K_J: begin
            pc_write = 1'b1;
            pc_op    = PC_JMP;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          K_JR: begin
            pc_write = 1'b1;
            pc_op    = PC_REG;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          K_JAL: begin
            pc_write = 1'b1;
            pc_op    = PC_JMP;
            state_d  = S_WB;
          end
          default: begin
            ext_op  = EXT_ZERO;
            state_d = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (kind_q == K_SW);
        if (mem_ready) begin
          if (kind_q == K_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (kind_q)
          K_ADDU, K_SUBU, K_AND, K_OR, K_SLT: reg_dst = 2'd1;
          K_LW:    reg_src = 2'd1;
          K_JAL:   begin reg_dst = 2'd2; reg_src = 2'd2; end
          default: reg_dst = 2'd0;
        endcase
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - table-driven bench for mc_control
module tb_mc_control;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, mem_sel, ir_write, pc_write;
  logic [1:0] pc_op;
  logic [2:0] alu_op;
  logic       alu_src;
  logic [1:0] ext_op;
  logic       reg_write;
  logic [1:0] reg_dst, reg_src;
  logic       retire, illegal;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_op(pc_op), .alu_op(alu_op),
    .alu_src(alu_src), .ext_op(ext_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .reg_src(reg_src), .retire(retire), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] outs;
  assign outs = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_op, alu_op, alu_src,
                 ext_op, reg_write, reg_dst, reg_src, retire, illegal};

  function automatic logic [19:0] pk(input logic mreq, input logic mwe, input logic msel,
                                     input logic irw, input logic pcw, input logic [1:0] pco,
                                     input logic [2:0] alu, input logic asrc, input logic [1:0] ext,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] rs,
                                     input logic ret, input logic ill);
    return {mreq, mwe, msel, irw, pcw, pco, alu, asrc, ext, rw, rd, rs, ret, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fw;
    int         mw;
    int         cycles;
    logic [2:0] alu;
    logic       asrc;
    logic [1:0] ext;
    logic       pcw;
    logic [1:0] pco;
    logic       eret;
    logic       has_mem;
    logic       we;
    logic       has_wb;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       scr;
  } vec_t;

  vec_t vecs[$];

  // Entered and left at posedge+1 with the DUT in FETCH
  task automatic run_vec(input vec_t v);
    int cyc, fcnt, mcnt, irw_n, rw_n, mem_n;
    logic rdy, done;
    logic [19:0] exp;
    opcode = v.op; funct = v.fn; zero = v.z;
    cyc = 0; fcnt = 0; mcnt = 0; irw_n = 0; rw_n = 0; mem_n = 0; done = 1'b0;
    while (!done && cyc < 30) begin
      if (v.scr && state != 3'd1 && state != 3'd2) begin
        opcode = 6'h3f;
        funct  = 6'($urandom_range(0, 63));
      end
      case (state)
        3'd1:    rdy = (fcnt >= v.fw);
        3'd4:    rdy = (mcnt >= v.mw);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      mem_ready = rdy;
      @(negedge clk);
      cyc++;
      case (state)
        3'd1: begin
          exp = pk(1, 0, 0, rdy, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0);
          chk({v.name, " fetch"}, outs, exp);
          if (!rdy) fcnt++;
        end
        3'd2: chk({v.name, " decode"}, outs, 20'd0);
        3'd3: begin
          exp = pk(0, 0, 0, 0, v.pcw, v.pco, v.alu, v.asrc, v.ext, 0, 0, 0, v.eret, 0);
          chk({v.name, " exec"}, outs, exp);
        end
        3'd4: begin
          exp = pk(1, v.we, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy & v.we, 0);
          chk({v.name, " mem"}, outs, exp);
          mem_n++;
          if (!rdy) mcnt++;
        end
        3'd5: begin
          exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, v.rd, v.rs, 1, 0);
          chk({v.name, " wb"}, outs, exp);
        end
        default: chk({v.name, " state"}, 32'(state), 32'hff);
      endcase
      if (ir_write) irw_n++;
      if (reg_write) rw_n++;
      if (retire) done = 1'b1;
      @(posedge clk); #1;
    end
    chk({v.name, " cycles"}, cyc, v.cycles);
    chk({v.name, " ir_write pulses"}, irw_n, 1);
    chk({v.name, " reg_write pulses"}, rw_n, 32'(v.has_wb));
    chk({v.name, " mem cycles"}, mem_n, v.has_mem ? v.mw + 1 : 0);
  endtask

  initial begin
    //                name       op     fn     z  fw mw cyc alu as ext pcw pco er hm we wb rd rs scr
    vecs.push_back('{"addu",     6'h00, 6'h21, 1, 0, 0, 4,  0,  0, 1,  0,  0,  0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{"subu",     6'h00, 6'h23, 0, 0, 0, 4,  1,  0, 1,  0,  0,  0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{"and",      6'h00, 6'h24, 1, 0, 0, 4,  2,  0, 1,  0,  0,  0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{"or",       6'h00, 6'h25, 0, 0, 0, 4,  3,  0, 1,  0,  0,  0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{"slt",      6'h00, 6'h2a, 0, 0, 0, 4,  4,  0, 1,  0,  0,  0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{"jr",       6'h00, 6'h08, 0, 0, 0, 3,  0,  0, 1,  1,  3,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"addiu",    6'h09, 6'h00, 1, 0, 0, 4,  0,  1, 1,  0,  0,  0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{"ori",      6'h0d, 6'h3f, 0, 0, 0, 4,  3,  1, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{"lui",      6'h0f, 6'h00, 0, 0, 0, 4,  5,  1, 2,  0,  0,  0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{"lw",       6'h23, 6'h00, 0, 0, 0, 5,  0,  1, 1,  0,  0,  0, 1, 0, 1, 0, 1, 0});
    vecs.push_back('{"sw",       6'h2b, 6'h00, 1, 0, 0, 4,  0,  1, 1,  0,  0,  0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"beq_t",    6'h04, 6'h00, 1, 0, 0, 3,  1,  0, 1,  1,  1,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"beq_nt",   6'h04, 6'h00, 0, 0, 0, 3,  1,  0, 1,  0,  1,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"j",        6'h02, 6'h00, 0, 0, 0, 3,  0,  0, 1,  1,  2,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"jal",      6'h03, 6'h00, 0, 0, 0, 4,  0,  0, 1,  1,  2,  0, 0, 0, 1, 2, 2, 0});
    vecs.push_back('{"lw_wait",  6'h23, 6'h00, 0, 2, 3, 10, 0,  1, 1,  0,  0,  0, 1, 0, 1, 0, 1, 1});
    vecs.push_back('{"sw_wait",  6'h2b, 6'h00, 0, 1, 2, 7,  0,  1, 1,  0,  0,  0, 1, 1, 0, 0, 0, 0});

    rst_n = 1'b0; opcode = 6'h00; funct = 6'h21; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'(state), 0);
    chk("reset outs", outs, 20'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("leave idle", 32'(state), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // illegal opcode: trap holds until reset
    opcode = 6'h3f; funct = 6'h00; mem_ready = 1'b1;
    @(negedge clk); chk("trap fetch state", 32'(state), 1);
    @(posedge clk); #1;
    @(negedge clk); chk("trap decode state", 32'(state), 2);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 6'($urandom_range(0, 63));
      @(negedge clk);
      chk("trap state", 32'(state), 6);
      chk("trap outs", outs, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    rst_n = 1'b0; #1;
    chk("trap reset state", 32'(state), 0);
    chk("trap reset outs", outs, 20'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("trap restart", 32'(state), 1);

    // reset in the middle of a stalled sw
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw stall state", 32'(state), 4);
    chk("sw stall outs", outs, pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("sw reset state", 32'(state), 0);
    chk("sw reset outs", outs, 20'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("sw reset held", outs, 20'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sw restart", 32'(state), 1);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
